// File: rtl/fifo_rr_scheduler_if.sv
// Bundle for the N-source / single-sink token handshake of fifo_rr_scheduler.
// master is the scheduler side, slave is the FIFO environment side.
interface fifo_rr_scheduler_if #(
  parameter int N     = 4,
  parameter int width = 8
);
  localparam int TAG_W = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]       in_empty_n;
  logic [N*width-1:0] in_dout;
  logic [N-1:0]       in_read;
  logic               out_full_n;
  logic [width-1:0]   out_din;
  logic               out_write;
  logic [TAG_W-1:0]   out_tag;

  modport master (
    input  in_empty_n, in_dout, out_full_n,
    output in_read, out_din, out_write, out_tag
  );

  modport slave (
    output in_empty_n, in_dout, out_full_n,
    input  in_read, out_din, out_write, out_tag
  );
endinterface

// File: rtl/fifo_rr_scheduler.sv
// Merges N source FIFOs into one sink through a round-robin grant held for up to
// `burst` tokens, with a one-entry output register for 1 token/cycle throughput.
//   state | meaning
//   IDLE  | arbitrate: pick first requester after `last`
//   GRANT | drain granted channel g until burst limit or empty
module fifo_rr_scheduler #(
  parameter int N     = 4,
  parameter int width = 8,
  parameter int burst = 4
) (
  input  logic              clk,
  input  logic              ap_rst,
  fifo_rr_scheduler_if.master bus
);
  localparam int TAG_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state, state_next;
  logic [TAG_W-1:0] last, g, sel, idx;
  logic [7:0]       burst_cnt;
  logic             any_req, g_req, pop, burst_done;
  logic             out_valid;
  logic [width-1:0] data_q;
  logic [TAG_W-1:0] tag_q;
  logic [N-1:0]     read_vec;
  logic             write;

  // Scan last+1, last+2, ... so the previously served channel has lowest priority
  always_comb begin
    sel     = '0;
    idx     = '0;
    any_req = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx = TAG_W'((int'(last) + k) % N);
      if (!any_req && bus.in_empty_n[idx]) begin
        any_req = 1'b1;
        sel     = idx;
      end
    end
  end

  assign g_req      = bus.in_empty_n[g];
  assign pop        = (state == GRANT) && g_req && (!out_valid || bus.out_full_n) && !ap_rst;
  assign burst_done = pop && (({1'b0, burst_cnt} + 9'd1) == 9'(burst));

  always_ff @(posedge clk) begin
    if (ap_rst) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_req) state_next = GRANT;
      GRANT:   if (!g_req || burst_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Strobes are forced low during reset so no FIFO is popped on the reset edge
  always_comb begin
    read_vec = pop ? (N'(1) << g) : '0;
    write    = out_valid && bus.out_full_n && !ap_rst;
  end

  assign bus.in_read   = read_vec;
  assign bus.out_write = write;
  assign bus.out_din   = data_q;
  assign bus.out_tag   = tag_q;

  always_ff @(posedge clk) begin
    if (ap_rst) begin
      last      <= TAG_W'(N - 1);
      g         <= '0;
      burst_cnt <= '0;
      out_valid <= 1'b0;
      data_q    <= '0;
      tag_q     <= '0;
    end else begin
      if (pop) begin
        data_q    <= bus.in_dout[g*width +: width];
        tag_q     <= g;
        out_valid <= 1'b1;
        burst_cnt <= burst_cnt + 8'd1;
      end else if (write) begin
        out_valid <= 1'b0;
      end
      if (state == IDLE && any_req) begin
        g         <= sel;
        burst_cnt <= '0;
      end
      if (state == GRANT && state_next == IDLE) last <= g;
    end
  end
endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Bench for fifo_rr_scheduler: queue-based source FIFOs, a transaction-level
// reference checked every cycle, directed scenarios and a randomized soak.
module tb_fifo_rr_scheduler;
  localparam int N = 4, W = 8, B = 4, TW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_rr_scheduler_if #(.N(N), .width(W)) bus  ();
  fifo_rr_scheduler_if #(.N(N), .width(W)) bus1 ();

  fifo_rr_scheduler #(.N(N), .width(W), .burst(B)) u_dut (.clk(clk), .ap_rst(rst), .bus(bus));
  fifo_rr_scheduler #(.N(N), .width(W), .burst(1)) u_thr (.clk(clk), .ap_rst(rst), .bus(bus1));

  int n_pass = 0, n_total = 0;

  logic [W-1:0] src [N][$];
  logic [N-1:0] rd_seen;
  bit  rand_full = 0, full_force = 1, chk_order = 0;
  int  arrive_pct = 0;
  int  cyc = 0, wr_cnt = 0, pushed = 0;
  int  rd_cnt [N];
  int  next_seq [N];
  int  push_seq [N];
  int  tag_log [$];
  int  wcyc_log [$];
  logic [W-1:0] din_log [$];

  // reference: current grant (if any), tokens taken, last served, held output token
  bit  m_busy = 0, m_hv = 0;
  int  m_ch = 0, m_cnt = 0, m_last = N-1, m_tag = 0;
  logic [W-1:0] m_tok = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic bit has(input int c);
    logic [TW-1:0] ci;
    ci = c[TW-1:0];
    return bus.in_empty_n[ci];
  endfunction

  task automatic drive_inputs();
    logic [N-1:0]   e;
    logic [N*W-1:0] d;
    for (int i = 0; i < N; i++) begin
      e[i] = (src[i].size() > 0);
      d[i*W +: W] = e[i] ? src[i][0] : W'($urandom);
    end
    bus.in_empty_n = e;
    bus.in_dout    = d;
    bus.out_full_n = rand_full ? ($urandom_range(0, 3) != 0) : full_force;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (rd_seen[i] && src[i].size() > 0) void'(src[i].pop_front());
    if (arrive_pct > 0)
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 99) < arrive_pct && src[i].size() < 6) begin
          src[i].push_back({3'(i), 5'(push_seq[i])});
          push_seq[i] = (push_seq[i] + 1) % 32;
          pushed++;
        end
    drive_inputs();
  endtask

  task automatic clear_logs();
    wr_cnt = 0;
    for (int i = 0; i < N; i++) rd_cnt[i] = 0;
    tag_log.delete(); din_log.delete(); wcyc_log.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_inputs();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic run_until(input int target, input int budget, input string name);
    int k = 0;
    while (wr_cnt < target && k < budget) begin
      step();
      k++;
    end
    if (wr_cnt < target) chk(name, 32'(wr_cnt), 32'(target));
  endtask

  always @(negedge clk) begin : compare
    logic [N-1:0] exp_rd;
    bit exp_wr, exp_pop, avail, found;
    int c, t;
    cyc++;
    exp_rd = '0; exp_wr = 0; exp_pop = 0; avail = 0;
    if (!rst) begin
      avail   = m_busy && has(m_ch);
      exp_wr  = m_hv && bus.out_full_n;
      exp_pop = avail && (!m_hv || bus.out_full_n);
      if (exp_pop) exp_rd = N'(1) << m_ch;
    end
    chk("in_read", 32'(bus.in_read), 32'(exp_rd));
    chk("out_write", 32'(bus.out_write), 32'(exp_wr));
    if (exp_wr && bus.out_write) begin
      chk("out_din", 32'(bus.out_din), 32'(m_tok));
      chk("out_tag", 32'(bus.out_tag), 32'(m_tag));
    end
    if (bus.out_write) begin
      t = int'(bus.out_tag);
      wr_cnt++;
      tag_log.push_back(t);
      din_log.push_back(bus.out_din);
      wcyc_log.push_back(cyc);
      if (chk_order) begin
        chk("order", 32'(bus.out_din[4:0]), 32'(next_seq[t]));
        chk("tag_field", 32'(bus.out_din[7:5]), 32'(bus.out_tag));
        next_seq[t] = (next_seq[t] + 1) % 32;
      end
    end
    for (int i = 0; i < N; i++) rd_cnt[i] += int'(bus.in_read[i]);
    rd_seen = bus.in_read;

    if (rst) begin
      m_busy = 0; m_hv = 0; m_ch = 0; m_cnt = 0; m_last = N-1; m_tok = '0; m_tag = 0;
      for (int i = 0; i < N; i++)
        next_seq[i] = (src[i].size() > 0) ? int'(src[i][0][4:0]) : push_seq[i];
    end else begin
      if (!m_busy) begin
        found = 0;
        for (int k = 1; k <= N; k++) begin
          c = (m_last + k) % N;
          if (!found && has(c)) begin
            found = 1; m_busy = 1; m_ch = c; m_cnt = 0;
          end
        end
      end else if (exp_pop) begin
        m_tok = bus.in_dout[m_ch*W +: W];
        m_tag = m_ch;
        m_hv  = 1;
        m_cnt++;
        if (m_cnt == B) begin m_busy = 0; m_last = m_ch; end
      end else if (!avail) begin
        m_busy = 0; m_last = m_ch;
      end
      if (!exp_pop && exp_wr) m_hv = 0;
    end
  end

  task automatic throughput_test();
    logic [W-1:0] tok, exp_tok;
    bit w, r, prev_w;
    int w_cnt, r_cnt;
    tok = 8'h40; exp_tok = 8'h40; w_cnt = 0; r_cnt = 0; prev_w = 0;
    bus1.in_dout = '0;
    bus1.in_dout[W-1:0] = tok;
    bus1.in_empty_n = 4'b0001;
    bus1.out_full_n = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      w = bus1.out_write;
      r = bus1.in_read[0];
      chk("thr_rd_other", 32'(bus1.in_read[3:1]), 32'd0);
      if (w) begin
        chk("thr_din", 32'(bus1.out_din), 32'(exp_tok));
        chk("thr_tag", 32'(bus1.out_tag), 32'd0);
        exp_tok = exp_tok + 8'd1;
      end
      if (k >= 10) begin
        if (k > 10) chk("thr_alternate", 32'(w), 32'(!prev_w));
        w_cnt += int'(w);
        r_cnt += int'(r);
      end
      prev_w = w;
      @(posedge clk);
      #1;
      if (r) tok = tok + 8'd1;
      bus1.in_dout[W-1:0] = tok;
    end
    chk("thr_writes", 32'(w_cnt), 32'd10);
    chk("thr_reads", 32'(r_cnt), 32'd10);
    bus1.in_empty_n = '0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [W-1:0] d0;
    logic [TW-1:0] t0;
    int rd_before, k;
    int exp_t [5];
    exp_t = '{2, 2, 3, 3, 3};
    for (int i = 0; i < N; i++) begin push_seq[i] = 0; rd_cnt[i] = 0; next_seq[i] = 0; end
    bus1.in_empty_n = '0; bus1.in_dout = '0; bus1.out_full_n = 1'b1;
    rst = 1'b1;
    drive_inputs();
    repeat (3) step();
    rst = 1'b0;
    #1;
    chk("rst_out_din", 32'(bus.out_din), 32'd0);
    chk("rst_out_tag", 32'(bus.out_tag), 32'd0);
    chk("rst_out_write", 32'(bus.out_write), 32'd0);
    chk("rst_in_read", 32'(bus.in_read), 32'd0);

    // single channel, 6 tokens, burst split 4 + 2
    clear_logs();
    for (int j = 0; j < 6; j++) src[1].push_back(8'h10 + 8'(j));
    drive_inputs();
    run_until(6, 40, "single_timeout");
    repeat (4) step();
    chk("single_count", 32'(tag_log.size()), 32'd6);
    if (tag_log.size() == 6) begin
      for (int j = 0; j < 6; j++) begin
        chk("single_din", 32'(din_log[j]), 32'(8'h10 + j));
        chk("single_tag", 32'(tag_log[j]), 32'd1);
      end
      for (int j = 0; j < 5; j++)
        chk("single_gap", 32'(wcyc_log[j+1] - wcyc_log[j]), (j == 3) ? 32'd2 : 32'd1);
    end
    chk("single_reads", 32'(rd_cnt[1]), 32'd6);

    // fairness: 4 channels x 8 tokens
    do_reset();
    clear_logs();
    for (int c = 0; c < N; c++)
      for (int j = 0; j < 8; j++) src[c].push_back({3'(c), 5'(j)});
    drive_inputs();
    run_until(32, 120, "fair_timeout");
    repeat (3) step();
    chk("fair_count", 32'(tag_log.size()), 32'd32);
    if (tag_log.size() == 32)
      for (int j = 0; j < 32; j++) begin
        chk("fair_tag", 32'(tag_log[j]), 32'((j / 4) % 4));
        chk("fair_din", 32'(din_log[j]), 32'({3'((j / 4) % 4), 5'((j / 16) * 4 + j % 4)}));
      end

    // back-pressure mid-burst
    do_reset();
    clear_logs();
    for (int j = 0; j < 8; j++) src[0].push_back(8'h20 + 8'(j));
    drive_inputs();
    run_until(2, 20, "bp_timeout");
    full_force = 0;
    drive_inputs();
    #1;
    d0 = bus.out_din; t0 = bus.out_tag; rd_before = rd_cnt[0];
    for (int j = 0; j < 5; j++) begin
      chk("bp_din_stable", 32'(bus.out_din), 32'(d0));
      chk("bp_tag_stable", 32'(bus.out_tag), 32'(t0));
      chk("bp_no_write", 32'(bus.out_write), 32'd0);
      step();
      #1;
    end
    chk("bp_pops_le1", 32'(rd_cnt[0] - rd_before <= 1), 32'd1);
    full_force = 1;
    drive_inputs();
    run_until(8, 40, "bp_resume_timeout");
    repeat (3) step();
    chk("bp_count", 32'(din_log.size()), 32'd8);
    if (din_log.size() == 8)
      for (int j = 0; j < 8; j++) begin
        chk("bp_din", 32'(din_log[j]), 32'(8'h20 + j));
        chk("bp_tag", 32'(tag_log[j]), 32'd0);
      end

    // early empty hand-over
    do_reset();
    clear_logs();
    for (int j = 0; j < 2; j++) src[2].push_back(8'h30 + 8'(j));
    for (int j = 0; j < 3; j++) src[3].push_back(8'h38 + 8'(j));
    drive_inputs();
    run_until(5, 40, "early_timeout");
    repeat (3) step();
    chk("early_count", 32'(tag_log.size()), 32'd5);
    if (tag_log.size() == 5)
      for (int j = 0; j < 5; j++) chk("early_tag", 32'(tag_log[j]), 32'(exp_t[j]));

    // reset after the 2nd pop of a burst
    do_reset();
    clear_logs();
    for (int j = 0; j < 6; j++) src[2].push_back(8'h50 + 8'(j));
    drive_inputs();
    k = 0;
    while (rd_cnt[2] < 2 && k < 20) begin step(); k++; end
    if (rd_cnt[2] < 2) chk("mid_rst_timeout", 32'(rd_cnt[2]), 32'd2);
    for (int j = 0; j < 3; j++) begin
      src[1].push_back(8'h60 + 8'(j));
      src[3].push_back(8'h70 + 8'(j));
    end
    rst = 1'b1;
    drive_inputs();
    step();
    rst = 1'b0;
    #1;
    chk("mid_rst_write", 32'(bus.out_write), 32'd0);
    clear_logs();
    run_until(1, 20, "mid_rst_grant_timeout");
    if (tag_log.size() > 0) begin
      chk("mid_rst_next_tag", 32'(tag_log[0]), 32'd1);
      chk("mid_rst_next_din", 32'(din_log[0]), 32'h60);
    end
    repeat (40) step();

    throughput_test();

    // randomized soak with random arrivals and random back-pressure
    do_reset();
    clear_logs();
    chk_order = 1;
    pushed = 0;
    rand_full = 1;
    arrive_pct = 30;
    repeat (3000) step();
    arrive_pct = 0;
    rand_full = 0;
    full_force = 1;
    drive_inputs();
    run_until(pushed, 400, "drain_timeout");
    repeat (3) step();
    chk("drain_count", 32'(wr_cnt), 32'(pushed));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/fifo_rr_scheduler.md
FIFO_RR_SCHEDULER -- requirements
Module: fifo_rr_scheduler

Interface
REQ-001 Parameter N, default 4, number of input FIFO channels (legal 2..8).
REQ-002 Parameter width, default 8, token width in bits.
REQ-003 Parameter burst, default 4, maximum tokens taken from one channel per grant (legal 1..255).
REQ-004 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 Port ap_rst  input  1  synchronous, active-high reset.
REQ-006 Port in_empty_n  input  N  per-channel "source FIFO not empty"; bit i belongs to channel i.
REQ-007 Port in_dout  input  N*width  per-channel head token; channel i occupies bits [i*width +: width]; valid in the same cycle its in_empty_n bit is high.
REQ-008 Port in_read  output  N  per-channel pop strobe; the source FIFO advances on the clock edge where the strobe is high.
REQ-009 Port out_full_n  input  1  sink FIFO can accept a token this cycle.
REQ-010 Port out_din  output  width  token presented to the sink.
REQ-011 Port out_write  output  1  sink write strobe.
REQ-012 Port out_tag  output  clog2(N)  source channel index of the token on out_din.

Function
REQ-013 The block shall merge N source FIFOs into one sink FIFO using a round-robin grant held for up to burst tokens.
REQ-014 The FSM shall have two states: IDLE (arbitrate) and GRANT (drain the granted channel g).
REQ-015 IDLE: if any in_empty_n bit is high, select the first requesting channel scanning last+1, last+2, ... modulo N; load g; clear the burst count; go to GRANT next cycle. Arbitration latency is 1 cycle.
REQ-016 IDLE: if no channel requests, remain in IDLE; no in_read bit is asserted.
REQ-017 The output stage shall be a one-entry register holding out_valid, out_din and out_tag.
REQ-018 out_write shall equal out_valid AND out_full_n combinationally; out_write shall never be high while out_full_n is low.
REQ-019 A pop ("pop") occurs when state is GRANT, in_empty_n[g] is high, and (out_valid is low or out_full_n is high); in_read[g] equals pop, and all other in_read bits are 0.
REQ-020 On a pop: out_din <= in_dout[g], out_tag <= g, out_valid <= 1, burst count +1.
REQ-021 If out_write is high and there is no pop, out_valid <= 0; simultaneous write and pop keep out_valid at 1 with the new token, giving full throughput of 1 token/cycle.
REQ-022 GRANT -> IDLE, with last <= g, when a pop makes the burst count reach burst, or when in_empty_n[g] is low.
REQ-023 GRANT shall persist while in_empty_n[g] is high and out_full_n back-pressure blocks the pop; back-pressure shall never cause rotation.
REQ-024 The burst count shall be 8 bits wide and shall never exceed burst.
REQ-025 Tokens from one channel shall leave in source order; no token shall be duplicated or dropped.
REQ-026 The latency from pop to out_write shall be 1 cycle when out_full_n is high.

Reset
REQ-027 While ap_rst is high at a clock edge: state = IDLE, last = N-1 (channel 0 has first priority), g = 0, burst count = 0, out_valid = 0, out_din = 0, out_tag = 0.
REQ-028 During and immediately after reset, in_read and out_write shall be all-zero.
REQ-029 Reset asserted mid-burst shall discard the held output token and any grant; the source FIFOs shall not be popped on that edge.

Verification
REQ-030 Single channel: ch1 holds 6 tokens (0x10..0x15), others empty, out_full_n = 1 -> output 0x10..0x13 tagged 1, one IDLE gap, then 0x14, 0x15; in_read[1] pulses exactly 6 times.
REQ-031 Fairness: all 4 channels each hold 8 tokens, burst = 4 -> tag sequence 0,0,0,0,1,1,1,1,2,...,3, then repeats; 32 tokens out with no loss.
REQ-032 Back-pressure: hold out_full_n low for 5 cycles mid-burst -> out_din/out_tag are stable, out_write = 0, at most one pop, and the burst resumes on the same channel.
REQ-033 Early empty: ch2 holds 2 tokens, ch3 holds 3 tokens -> ch2 is granted, emits 2 tokens, then ch3 is granted without waiting for the burst limit; the tag order is 2,2,3,3,3.
REQ-034 Reset mid-burst: assert ap_rst for 1 cycle after the 2nd pop of a burst -> out_valid = 0 next cycle; the next grant goes to the lowest-index non-empty channel.
REQ-035 Throughput: ch0 streams continuously, burst = 1, other channels empty -> ch0 is re-granted every 2 cycles (GRANT, IDLE alternating); out_write duty is 50%.
